// File: rtl/fft_pkg.sv
// fft_pkg: shared constants and packed-field helpers for the radix-2 twiddle butterfly.
//   Data words pack {re, im} as two signed 16-bit halves; twiddles pack {re, im}
//   as two signed 10-bit halves with unity = 1 << TF_SHIFT.
package fft_pkg;

    localparam int TF_SHIFT     = 8;
    localparam int TF_ROUND     = 128;
    localparam int BFLY_LATENCY = 4;

    localparam int XH     = 16;
    localparam int TFH    = 10;
    localparam int PROD_W = XH + TFH;
    localparam int RND_W  = 18;
    localparam int SUM_W  = 19;

    function automatic logic signed [XH-1:0] x_re(input logic [2*XH-1:0] x);
        return x[2*XH-1:XH];
    endfunction

    function automatic logic signed [XH-1:0] x_im(input logic [2*XH-1:0] x);
        return x[XH-1:0];
    endfunction

    function automatic logic signed [TFH-1:0] tf_re(input logic [2*TFH-1:0] w);
        return w[2*TFH-1:TFH];
    endfunction

    function automatic logic signed [TFH-1:0] tf_im(input logic [2*TFH-1:0] w);
        return w[TFH-1:0];
    endfunction

    // Halves a 19-bit sum (floor) and clamps it to 16 bits; returns {clamped, value}.
    // The halved value fits in 16 bits exactly when the top three sum bits agree.
    function automatic logic [XH:0] sat_half(input logic [SUM_W-1:0] s);
        logic ovf;
        ovf = !(&s[SUM_W-1:XH] || ~|s[SUM_W-1:XH]);
        return ovf ? {1'b1, s[SUM_W-1], {(XH-1){~s[SUM_W-1]}}} : {1'b0, s[XH:1]};
    endfunction

endpackage

// File: rtl/cmult_pipe.sv
// cmult_pipe: two-register complex multiply B*W with rounding back to twiddle scale.
//   clk, rst  : clock, asynchronous active-high reset
//   v_i/v_o   : sample valid in / out (two cycles later)
//   a_i/a_o   : operand A carried alongside the multiply
//   m_i/m_o   : metadata tag carried alongside the multiply
//   b_i, w_i  : data operand B and twiddle W
//   pr_o/pi_o : round((B*W) / 2^TF_SHIFT), real and imaginary, 18-bit signed
module cmult_pipe
    import fft_pkg::*;
#(
    parameter int A_W = 32,
    parameter int B_W = 32,
    parameter int W_W = 20,
    parameter int M_W = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    v_i,
    input  logic [A_W-1:0]          a_i,
    input  logic [B_W-1:0]          b_i,
    input  logic [W_W-1:0]          w_i,
    input  logic [M_W-1:0]          m_i,
    output logic                    v_o,
    output logic [A_W-1:0]          a_o,
    output logic [M_W-1:0]          m_o,
    output logic signed [RND_W-1:0] pr_o,
    output logic signed [RND_W-1:0] pi_o
);

    logic                     v2_q, v3_q;
    logic [A_W-1:0]           a2_q, a3_q;
    logic [M_W-1:0]           m2_q, m3_q;
    logic signed [PROD_W-1:0] rr_d, ii_d, ri_d, ir_d;
    logic signed [PROD_W-1:0] rr_q, ii_q, ri_q, ir_q;
    logic signed [PROD_W:0]   pr_sum, pi_sum;
    logic signed [RND_W-1:0]  pr_d, pi_d, pr_q, pi_q;

    always_comb begin
        rr_d   = PROD_W'(x_re(b_i)) * PROD_W'(tf_re(w_i));
        ii_d   = PROD_W'(x_im(b_i)) * PROD_W'(tf_im(w_i));
        ri_d   = PROD_W'(x_re(b_i)) * PROD_W'(tf_im(w_i));
        ir_d   = PROD_W'(x_im(b_i)) * PROD_W'(tf_re(w_i));
        pr_sum = (PROD_W+1)'(rr_q) - (PROD_W+1)'(ii_q) + (PROD_W+1)'(TF_ROUND);
        pi_sum = (PROD_W+1)'(ri_q) + (PROD_W+1)'(ir_q) + (PROD_W+1)'(TF_ROUND);
        // Slicing above TF_SHIFT is the arithmetic shift, kept at 18 bits.
        pr_d   = pr_sum[TF_SHIFT +: RND_W];
        pi_d   = pi_sum[TF_SHIFT +: RND_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            a2_q <= '0;
            a3_q <= '0;
            m2_q <= '0;
            m3_q <= '0;
            rr_q <= '0;
            ii_q <= '0;
            ri_q <= '0;
            ir_q <= '0;
            pr_q <= '0;
            pi_q <= '0;
        end else begin
            v2_q <= v_i;
            a2_q <= a_i;
            m2_q <= m_i;
            rr_q <= rr_d;
            ii_q <= ii_d;
            ri_q <= ri_d;
            ir_q <= ir_d;
            v3_q <= v2_q;
            a3_q <= a2_q;
            m3_q <= m2_q;
            pr_q <= pr_d;
            pi_q <= pi_d;
        end
    end

    assign v_o  = v3_q;
    assign a_o  = a3_q;
    assign m_o  = m3_q;
    assign pr_o = pr_q;
    assign pi_o = pi_q;

endmodule

// File: rtl/fft_butterfly_tf.sv
// fft_butterfly_tf: radix-2 DIT butterfly fed directly by the 512-point twiddle ROM.
//   clk, rst          : clock, asynchronous active-high reset
//   in_nd             : input valid; in_addr selects the twiddle for this butterfly
//   in_a, in_b, in_m  : operands A, B ({re, im}) and metadata tag
//   tf_addr/tf_addr_nd: ROM address and read strobe (combinational)
//   tf_in             : ROM data, one cycle after the strobe
//   out_nd            : output valid, four cycles after in_nd
//   out_x, out_y      : (A + W*B)/2 and (A - W*B)/2, saturated; held between samples
//   out_m, out_ovf    : aligned tag and "any half clamped" flag
module fft_butterfly_tf
    import fft_pkg::*;
#(
    parameter int X_WIDTH    = 32,
    parameter int TF_WIDTH   = 20,
    parameter int ADDR_WIDTH = 8,
    parameter int M_WIDTH    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_nd,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [X_WIDTH-1:0]    in_a,
    input  logic [X_WIDTH-1:0]    in_b,
    input  logic [M_WIDTH-1:0]    in_m,
    output logic [ADDR_WIDTH-1:0] tf_addr,
    output logic                  tf_addr_nd,
    input  logic [TF_WIDTH-1:0]   tf_in,
    output logic                  out_nd,
    output logic [X_WIDTH-1:0]    out_x,
    output logic [X_WIDTH-1:0]    out_y,
    output logic [M_WIDTH-1:0]    out_m,
    output logic                  out_ovf
);

    logic                    s1_v_q;
    logic [X_WIDTH-1:0]      s1_a_q, s1_b_q;
    logic [M_WIDTH-1:0]      s1_m_q;
    logic                    s3_v;
    logic [X_WIDTH-1:0]      s3_a;
    logic [M_WIDTH-1:0]      s3_m;
    logic signed [RND_W-1:0] s3_pr, s3_pi;
    logic [XH:0]             xr, xi, yr, yi;
    logic [X_WIDTH-1:0]      out_x_d, out_y_d;
    logic                    out_ovf_d;
    logic                    out_nd_q, out_ovf_q;
    logic [X_WIDTH-1:0]      out_x_q, out_y_q;
    logic [M_WIDTH-1:0]      out_m_q;

    assign tf_addr    = in_addr;
    assign tf_addr_nd = in_nd & ~rst;

    // Stage 1 delays the operands to meet the ROM's one-cycle read latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v_q <= 1'b0;
            s1_a_q <= '0;
            s1_b_q <= '0;
            s1_m_q <= '0;
        end else begin
            s1_v_q <= in_nd;
            s1_a_q <= in_a;
            s1_b_q <= in_b;
            s1_m_q <= in_m;
        end
    end

    cmult_pipe #(
        .A_W (X_WIDTH),
        .B_W (X_WIDTH),
        .W_W (TF_WIDTH),
        .M_W (M_WIDTH)
    ) u_cmult (
        .clk  (clk),
        .rst  (rst),
        .v_i  (s1_v_q),
        .a_i  (s1_a_q),
        .b_i  (s1_b_q),
        .w_i  (tf_in),
        .m_i  (s1_m_q),
        .v_o  (s3_v),
        .a_o  (s3_a),
        .m_o  (s3_m),
        .pr_o (s3_pr),
        .pi_o (s3_pi)
    );

    always_comb begin
        xr        = sat_half(SUM_W'(x_re(s3_a)) + SUM_W'(s3_pr));
        xi        = sat_half(SUM_W'(x_im(s3_a)) + SUM_W'(s3_pi));
        yr        = sat_half(SUM_W'(x_re(s3_a)) - SUM_W'(s3_pr));
        yi        = sat_half(SUM_W'(x_im(s3_a)) - SUM_W'(s3_pi));
        out_x_d   = {xr[XH-1:0], xi[XH-1:0]};
        out_y_d   = {yr[XH-1:0], yi[XH-1:0]};
        out_ovf_d = xr[XH] | xi[XH] | yr[XH] | yi[XH];
    end

    // Output registers only load on a valid sample so bubbles hold the last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_nd_q  <= 1'b0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            out_m_q   <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            out_nd_q <= s3_v;
            if (s3_v) begin
                out_x_q   <= out_x_d;
                out_y_q   <= out_y_d;
                out_m_q   <= s3_m;
                out_ovf_q <= out_ovf_d;
            end
        end
    end

    assign out_nd  = out_nd_q;
    assign out_x   = out_x_q;
    assign out_y   = out_y_q;
    assign out_m   = out_m_q;
    assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_fft_butterfly_tf.sv
// tb_fft_butterfly_tf: randomized and directed bench for fft_butterfly_tf against an arithmetic model.
module tb_fft_butterfly_tf;
    import fft_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_nd = 1'b0;
    logic [7:0]  in_addr = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [0:0]  in_m = '0;
    logic [7:0]  tf_addr;
    logic        tf_addr_nd;
    logic [19:0] tf_in = '0;
    logic        out_nd;
    logic [31:0] out_x, out_y;
    logic [0:0]  out_m;
    logic        out_ovf;

    logic [19:0] rom [256];
    logic        hist_v [4096];
    logic [31:0] hist_x [4096];
    logic [31:0] hist_y [4096];
    logic        hist_m [4096];
    logic        hist_o [4096];
    logic [31:0] last_x = '0, last_y = '0;
    logic        last_m = 1'b0, last_o = 1'b0;
    int          t = 0;
    int          n_vec = 0;
    int          n_err = 0;

    fft_butterfly_tf dut (
        .clk        (clk),
        .rst        (rst),
        .in_nd      (in_nd),
        .in_addr    (in_addr),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_m       (in_m),
        .tf_addr    (tf_addr),
        .tf_addr_nd (tf_addr_nd),
        .tf_in      (tf_in),
        .out_nd     (out_nd),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_m      (out_m),
        .out_ovf    (out_ovf)
    );

    always #5 clk = ~clk;

    // Twiddle ROM: one-cycle registered read.
    always @(posedge clk) if (tf_addr_nd) tf_in <= rom[tf_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h step=%0d", tag, got, exp, t);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int clamp(input int v);
        return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
    endfunction

    // Returns {ovf, x, y} computed from the butterfly definition with integer arithmetic.
    function automatic logic [64:0] bfly(input logic [31:0] a, input logic [31:0] b, input logic [19:0] w);
        int ar, ai, br, bi, wr, wi, pr, pi, xr, xi, yr, yi;
        logic ovf;
        ar = int'($signed(a[31:16]));
        ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16]));
        bi = int'($signed(b[15:0]));
        wr = int'($signed(w[19:10]));
        wi = int'($signed(w[9:0]));
        pr = (br * wr - bi * wi + 128) >>> 8;
        pi = (br * wi + bi * wr + 128) >>> 8;
        xr = (ar + pr) >>> 1;
        xi = (ai + pi) >>> 1;
        yr = (ar - pr) >>> 1;
        yi = (ai - pi) >>> 1;
        ovf = (clamp(xr) != xr) || (clamp(xi) != xi) || (clamp(yr) != yr) || (clamp(yi) != yi);
        return {ovf, 16'(clamp(xr)), 16'(clamp(xi)), 16'(clamp(yr)), 16'(clamp(yi))};
    endfunction

    task automatic step(input logic v, input logic [7:0] ad, input logic [31:0] a, input logic [31:0] b,
                        input logic m, input logic r);
        logic [64:0] e;
        @(posedge clk);
        #1;
        if (t >= BFLY_LATENCY && hist_v[t-BFLY_LATENCY]) begin
            check("out_nd", 32'(out_nd), 32'd1);
            check("out_x", out_x, hist_x[t-BFLY_LATENCY]);
            check("out_y", out_y, hist_y[t-BFLY_LATENCY]);
            check("out_m", 32'(out_m), 32'(hist_m[t-BFLY_LATENCY]));
            check("out_ovf", 32'(out_ovf), 32'(hist_o[t-BFLY_LATENCY]));
            last_x = hist_x[t-BFLY_LATENCY];
            last_y = hist_y[t-BFLY_LATENCY];
            last_m = hist_m[t-BFLY_LATENCY];
            last_o = hist_o[t-BFLY_LATENCY];
        end else begin
            check("out_nd_idle", 32'(out_nd), 32'd0);
            check("hold_x", out_x, last_x);
            check("hold_y", out_y, last_y);
            check("hold_m", 32'(out_m), 32'(last_m));
            check("hold_ovf", 32'(out_ovf), 32'(last_o));
        end
        rst = r;
        in_nd = v;
        in_addr = ad;
        in_a = a;
        in_b = b;
        in_m = m;
        if (r) begin
            for (int j = 0; j <= t; j++) hist_v[j] = 1'b0;
            last_x = '0;
            last_y = '0;
            last_m = 1'b0;
            last_o = 1'b0;
        end
        e = bfly(a, b, rom[ad]);
        hist_v[t] = v && !r;
        hist_o[t] = e[64];
        hist_x[t] = e[63:32];
        hist_y[t] = e[31:0];
        hist_m[t] = m;
        #1;
        check("tf_addr_nd", 32'(tf_addr_nd), 32'(v && !r));
        check("tf_addr", 32'(tf_addr), 32'(ad));
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin
            int wr, wi;
            wr = rnd(256.0 * $cos(2.0 * 3.14159265358979 * k / 512.0));
            wi = rnd(-256.0 * $sin(2.0 * 3.14159265358979 * k / 512.0));
            rom[k] = {10'(wr), 10'(wi)};
        end
        for (int k = 0; k < 4096; k++) hist_v[k] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_nd", 32'(out_nd), 32'd0);
        check("rst_x", out_x, 32'd0);
        check("rst_y", out_y, 32'd0);
        check("rst_m", 32'(out_m), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        check("rst_tf_nd", 32'(tf_addr_nd), 32'd0);

        // Unity twiddle
        step(1'b1, 8'd0, {16'd100, 16'd0}, {16'd200, 16'd0}, 1'b1, 1'b0);
        idle(4);
        check("unity_x", out_x, {16'd150, 16'd0});
        check("unity_y", out_y, {16'hFFCE, 16'd0});
        check("unity_ovf", 32'(out_ovf), 32'd0);
        // -j twiddle
        step(1'b1, 8'd128, {16'd100, 16'd0}, {16'd200, 16'd0}, 1'b0, 1'b0);
        idle(4);
        check("negj_x", out_x, {16'd50, 16'hFF9C});
        check("negj_y", out_y, {16'd50, 16'd100});
        // Saturation with W = (181, -181)
        step(1'b1, 8'd64, {16'h0000, 16'h8000}, {16'h7FFF, 16'h8000}, 1'b1, 1'b0);
        idle(4);
        check("sat_x", out_x, {16'hFFFF, 16'h8000});
        check("sat_y", out_y, {16'h0000, 16'd6783});
        check("sat_ovf", 32'(out_ovf), 32'd1);

        // Streaming through every twiddle address
        for (int i = 0; i < 256; i++) step(1'b1, 8'(i), $urandom, $urandom, 1'(i), 1'b0);
        idle(5);

        // Bubble pattern 1,0,1,1,0
        step(1'b1, 8'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        step(1'b0, 8'($urandom), $urandom, $urandom, 1'b0, 1'b0);
        step(1'b1, 8'($urandom), $urandom, $urandom, 1'b0, 1'b0);
        step(1'b1, 8'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        step(1'b0, 8'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        idle(5);

        // Reset with three samples in flight; in_nd held high during reset
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
        step(1'b1, 8'($urandom), $urandom, $urandom, 1'b1, 1'b1);
        idle(6);
        step(1'b1, 8'($urandom), $urandom, $urandom, 1'b1, 1'b0);
        idle(5);

        // Random traffic with gaps and full-range operands
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 8'($urandom), $urandom, $urandom, 1'($urandom), 1'b0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
